// File: rtl/sram_port_arb.sv
// rtl/sram_port_arb.sv - two-requester round-robin arbiter for a single SRAM port
module sram_port_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int NUM_WMASKS = 4,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  we0_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    input  logic [NUM_WMASKS-1:0] wmask0_i,
    input  logic [NUM_WMASKS-1:0] wmask1_i,
    output logic                  gnt0_o,
    output logic                  gnt1_o,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic                  busy_o,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [2:0] RD_LAT_CNT = 3'(RD_LAT);

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    prio_q, prio_d;     // requester that wins when both ask
    logic                    owner_q, owner_d;   // requester of the transaction in flight
    logic                    we_q, we_d;
    logic                    gnt0_q, gnt0_d;
    logic                    gnt1_q, gnt1_d;
    logic                    rvalid0_q, rvalid0_d;
    logic                    rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
    logic                    busy_q, busy_d;
    logic                    csb_q, csb_d;
    logic                    web_q, web_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic [NUM_WMASKS-1:0]   wmask_q, wmask_d;
    logic                    winner;

    // Next state and next registered outputs; every output is a flop driven from here.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        we_d      = we_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        addr_d    = addr_q;
        din_d     = din_q;
        wmask_d   = wmask_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        csb_d     = 1'b1;
        web_d     = 1'b1;
        winner    = (req0_i && req1_i) ? prio_q : req1_i;

        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    state_d = ISSUE;
                    owner_d = winner;
                    prio_d  = ~winner;
                    we_d    = winner ? we1_i    : we0_i;
                    addr_d  = winner ? addr1_i  : addr0_i;
                    din_d   = winner ? wdata1_i : wdata0_i;
                    wmask_d = winner ? wmask1_i : wmask0_i;
                    csb_d   = 1'b0;
                    web_d   = winner ? ~we1_i : ~we0_i;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                    if (owner_q) rvalid1_d = 1'b1;
                    else         rvalid0_d = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = RD_LAT_CNT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                    if (owner_q) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = sram_dout;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = sram_dout;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, payload and output registers.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            busy_q    <= 1'b0;
            csb_q     <= 1'b1;
            web_q     <= 1'b1;
            addr_q    <= '0;
            din_q     <= '0;
            wmask_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            busy_q    <= busy_d;
            csb_q     <= csb_d;
            web_q     <= web_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            wmask_q   <= wmask_d;
        end
    end

    assign gnt0_o     = gnt0_q;
    assign gnt1_o     = gnt1_q;
    assign rvalid0_o  = rvalid0_q;
    assign rvalid1_o  = rvalid1_q;
    assign rdata0_o   = rdata0_q;
    assign rdata1_o   = rdata1_q;
    assign busy_o     = busy_q;
    assign sram_csb   = csb_q;
    assign sram_web   = web_q;
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;
    assign sram_wmask = wmask_q;

endmodule
